yolo_cbl_stream: RTL and testbench
==================================

Name: yolo_cbl_stream

Overview:
Parametrised streaming CBL post-processing stage for the YOLO accelerator. It takes signed convolution accumulator results, one per channel, and applies a per-channel batch-norm affine transform (fixed-point scale, rounding, bias). It then applies a selectable activation (linear, ReLU, clipped ReLU, leaky ReLU) and saturates to the output width. It sits between the conv engine output and the feature-map write-back, with valid/ready handshakes on both sides and a runtime coefficient write port.

Parameters:
IN_WIDTH, 16, signed accumulator input width
OUT_WIDTH, 8, signed output width
COEF_WIDTH, 8, signed per-channel scale width
FRAC_SHIFT, 4, fractional bits of scale (>=1); scale 1.0 = 1<<FRAC_SHIFT
CHANNELS, 4, number of channels interleaved on the stream (>=2)
LEAKY_SHIFT, 3, leaky slope = 2^-LEAKY_SHIFT
MAX_VAL, 6, upper clip for clipped-ReLU mode, in output LSBs

Ports:
clk_en  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  coefficient write strobe
cfg_ch  in  clog2(CHANNELS)  channel index for write
cfg_scale  in  COEF_WIDTH  signed scale
cfg_bias  in  OUT_WIDTH+4  signed bias, in post-shift units
mode  in  2  activation: 0 linear, 1 ReLU, 2 clipped ReLU, 3 leaky
in_valid  in  1  input beat valid
in_ready  out  1  input accepted when in_valid&&in_ready
in_data  in  IN_WIDTH  signed accumulator value
in_last  in  1  last beat of frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  OUT_WIDTH  signed activated result
out_ch  out  clog2(CHANNELS)  channel of out_data
out_last  out  1  in_last carried through
err_align  out  1  sticky: in_last seen when channel counter != CHANNELS-1

Behaviour:
- Reset (rst=1 at an edge): all stage valids 0, out_valid=0, out_data=0, out_ch=0, out_last=0, channel counter 0, err_align=0. Every channel's scale is set to 1<<FRAC_SHIFT and its bias to 0. Reset mid-stream discards all in-flight beats and takes priority over cfg_we.
- Pipeline: 3 stages (S1 multiply, S2 round/shift/bias, S3 activate/saturate). Latency is 3 cycles from accept to out_valid when never stalled. Throughput is 1 beat/cycle.
- Stall: stall = out_valid && !out_ready. All stages hold while stall=1. in_ready = !stall, which is a combinational path from out_ready. When out_valid=1, out_data, out_ch and out_last are stable until the beat is accepted.
- Bubbles do not block: an empty stage is filled even when a later stage holds.
- Channel counter: increments on each accepted beat and wraps from CHANNELS-1 to 0. An accepted beat with in_last=1 forces the counter to 0. If the counter was not CHANNELS-1 at that point, err_align is set and stays set until rst.
- S1: prod = in_data * scale[ch], full width IN_WIDTH+COEF_WIDTH signed. mode, ch and last are captured with the beat, so a mode change affects only later beats.
- Coefficients are read when the beat enters S1. A cfg write in the same cycle to the same channel is not seen by that beat; it takes effect from the next cycle.
- S2: v = ((prod + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT) + sign-extended bias. This rounds half toward +inf. The width is wide enough that there is no internal overflow.
- S3 activation on v:
  - mode 0: v unchanged.
  - mode 1: max(v, 0).
  - mode 2: min(max(v, 0), MAX_VAL).
  - mode 3: v for v>=0, otherwise v >>> LEAKY_SHIFT (floor).
  - The result then saturates to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].

Decomposition:
- Shared package yolo_pkg holds:
  - the activation mode encodings (ACT_LINEAR=0, ACT_RELU=1, ACT_CLIP=2, ACT_LEAKY=3);
  - a 2-bit act_mode_t;
  - a saturating-resize function reused by other accelerator stages.
- One sub-module: yolo_act_sat, the combinational S3 activation and saturation taking (v, mode) and producing out_data. It is also reusable by the pooling path.
- The coefficient register file and pipeline stay in yolo_cbl_stream.

Test Plan:
- Reset, mode 0, out_ready=1, accept in_data=100 on ch0 -> out_data=100, out_ch=0, out_valid exactly 3 cycles after accept.
- Write ch1 scale=32, bias=-5. Stream ch0=10, ch1=10 -> outputs 10, 15 in order with out_ch 0, 1.
- Rounding: ch0 scale=24, bias 0, in=3 -> 5; in=-3 -> -4.
- Modes:
  - in=-40 -> mode 1 gives 0, mode 3 gives -5.
  - in=50 in mode 2 -> 6.
  - mode 0: in=1000 -> 127; in=-1000 -> -128.
- Backpressure: offer 6 back-to-back beats, hold out_ready=0 for 5 cycles -> in_ready=0 while stalled, output stable, all 6 emerge in order with no loss or duplication.
- Alignment and reset:
  - in_last on the 2nd beat (CHANNELS=4) -> err_align=1, next beat tagged ch0.
  - rst with 3 beats in flight -> out_valid=0 next cycle, err_align=0, scales restored to 16.

Source files
------------

// File: rtl/yolo_pkg.sv
// ---------------------------------------------------------------------------
// yolo_pkg
// Definitions shared by the YOLO accelerator post-processing stages.
//   act_mode_t  : 2-bit activation selector (linear, ReLU, clipped ReLU, leaky)
//   sat_resize  : clamps a wide signed value to the range of an N-bit signed
//                 number; the caller truncates the result to N bits
// ---------------------------------------------------------------------------
package yolo_pkg;

    typedef enum logic [1:0] {
        ACT_LINEAR = 2'd0,
        ACT_RELU   = 2'd1,
        ACT_CLIP   = 2'd2,
        ACT_LEAKY  = 2'd3
    } act_mode_t;

    // Values are carried in 64 bits so that any stage (conv, pooling) can
    // hand over its internal width without a dedicated function per width.
    function automatic logic signed [63:0] sat_resize(
        input logic signed [63:0] value,
        input int                 out_width
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/yolo_act_sat.sv
// ---------------------------------------------------------------------------
// yolo_act_sat
// Combinational activation followed by saturation to the output width.
// Shared by the CBL stage and the pooling path.
//   v        in  V_WIDTH    signed pre-activation value
//   mode     in  act_mode_t activation selector
//   out_data out OUT_WIDTH  signed, activated and saturated result
// ---------------------------------------------------------------------------
module yolo_act_sat
    import yolo_pkg::*;
#(
    parameter int V_WIDTH     = 26,
    parameter int OUT_WIDTH   = 8,
    parameter int LEAKY_SHIFT = 3,
    parameter int MAX_VAL     = 6
) (
    input  logic signed [V_WIDTH-1:0]   v,
    input  act_mode_t                   mode,
    output logic signed [OUT_WIDTH-1:0] out_data
);

    logic signed [63:0] v_ext;
    logic signed [63:0] act;

    // The activation is evaluated at 64 bits so that the leaky shift and
    // the clip bound never interact with the narrower output width; the
    // saturation afterwards is the only place where range is lost.
    always_comb begin
        v_ext = 64'(v);
        act   = v_ext;
        case (mode)
            ACT_LINEAR: act = v_ext;
            ACT_RELU:   act = (v_ext < 64'sd0) ? 64'sd0 : v_ext;
            ACT_CLIP: begin
                if (v_ext < 64'sd0) begin
                    act = 64'sd0;
                end else if (v_ext > 64'(MAX_VAL)) begin
                    act = 64'(MAX_VAL);
                end else begin
                    act = v_ext;
                end
            end
            ACT_LEAKY:  act = (v_ext < 64'sd0) ? (v_ext >>> LEAKY_SHIFT) : v_ext;
            default:    act = v_ext;
        endcase
        out_data = OUT_WIDTH'(sat_resize(act, OUT_WIDTH));
    end

endmodule

// File: rtl/yolo_cbl_stream.sv
// ---------------------------------------------------------------------------
// yolo_cbl_stream
// Streaming conv post-processing: per-channel batch-norm affine transform
// (fixed-point scale, round half up, bias), activation and saturation.
// Three register stages: S1 multiply, S2 round/shift/bias, S3 activate.
//   clk_en    in  1           clock, rising edge
//   rst       in  1           synchronous active-high reset
//   cfg_we    in  1           coefficient write strobe
//   cfg_ch    in  CH_W        channel written
//   cfg_scale in  COEF_WIDTH  signed scale, FRAC_SHIFT fractional bits
//   cfg_bias  in  OUT_WIDTH+4 signed bias in post-shift units
//   mode      in  2           activation mode, captured per beat
//   in_valid/in_ready/in_data/in_last   input stream
//   out_valid/out_ready/out_data/out_ch/out_last  output stream
//   err_align out 1           sticky frame/channel misalignment flag
// ---------------------------------------------------------------------------
module yolo_cbl_stream
    import yolo_pkg::*;
#(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int COEF_WIDTH  = 8,
    parameter int FRAC_SHIFT  = 4,
    parameter int CHANNELS    = 4,
    parameter int LEAKY_SHIFT = 3,
    parameter int MAX_VAL     = 6,
    localparam int CH_W       = $clog2(CHANNELS),
    localparam int BIAS_W     = OUT_WIDTH + 4
) (
    input  logic                         clk_en,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [CH_W-1:0]              cfg_ch,
    input  logic signed [COEF_WIDTH-1:0] cfg_scale,
    input  logic signed [BIAS_W-1:0]     cfg_bias,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_WIDTH-1:0]   in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_last,
    output logic                         err_align
);

    localparam int PROD_W = IN_WIDTH + COEF_WIDTH;
    // Two spare bits cover the rounding carry and the bias addition.
    localparam int V_W = PROD_W + 2;
    localparam logic signed [COEF_WIDTH-1:0] SCALE_ONE = COEF_WIDTH'(1 << FRAC_SHIFT);
    localparam logic signed [V_W-1:0]        ROUND_ADD = V_W'(1 << (FRAC_SHIFT - 1));
    localparam logic [CH_W-1:0]              CH_LAST   = CH_W'(CHANNELS - 1);

    logic signed [COEF_WIDTH-1:0] scale_q [CHANNELS];
    logic signed [BIAS_W-1:0]     bias_q  [CHANNELS];
    logic [CH_W-1:0]              ch_cnt;

    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic signed [BIAS_W-1:0] s1_bias;
    act_mode_t                s1_mode;
    logic [CH_W-1:0]          s1_ch;
    logic                     s1_last;

    logic                     s2_valid;
    logic signed [V_W-1:0]    s2_v;
    act_mode_t                s2_mode;
    logic [CH_W-1:0]          s2_ch;
    logic                     s2_last;

    logic                     stall;
    logic                     accept;
    logic                     s1_en;
    logic                     s2_en;
    logic                     s3_en;
    logic signed [V_W-1:0]    s2_next;
    logic signed [OUT_WIDTH-1:0] act_out;

    // Only the output register is held by backpressure directly; earlier
    // stages advance whenever the stage after them is empty or moving, so
    // a bubble inside the pipe is squeezed out even during a stall.
    always_comb begin
        stall    = out_valid && !out_ready;
        in_ready = !stall;
        accept   = in_valid && in_ready;
        s3_en    = !stall;
        s2_en    = !s2_valid || s3_en;
        s1_en    = !s1_valid || s2_en;
    end

    // Round half toward +inf, drop the fractional bits, then add the bias
    // which is already expressed in post-shift units.
    always_comb begin
        s2_next = ((V_W'(s1_prod) + ROUND_ADD) >>> FRAC_SHIFT) + V_W'(s1_bias);
    end

    yolo_act_sat #(
        .V_WIDTH     (V_W),
        .OUT_WIDTH   (OUT_WIDTH),
        .LEAKY_SHIFT (LEAKY_SHIFT),
        .MAX_VAL     (MAX_VAL)
    ) u_act_sat (
        .v        (s2_v),
        .mode     (s2_mode),
        .out_data (act_out)
    );

    // Coefficient file. A beat entering S1 on the same edge as a write
    // reads the old value because both sample the registers before update.
    always_ff @(posedge clk_en) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                scale_q[i] <= SCALE_ONE;
                bias_q[i]  <= '0;
            end
        end else if (cfg_we && (int'(cfg_ch) < CHANNELS)) begin
            scale_q[cfg_ch] <= cfg_scale;
            bias_q[cfg_ch]  <= cfg_bias;
        end
    end

    // Channel counter tracks the interleave position; a frame end resyncs
    // it to channel 0 and flags the frame if it ended mid-group.
    always_ff @(posedge clk_en) begin
        if (rst) begin
            ch_cnt    <= '0;
            err_align <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                ch_cnt <= '0;
                if (ch_cnt != CH_LAST) begin
                    err_align <= 1'b1;
                end
            end else if (ch_cnt == CH_LAST) begin
                ch_cnt <= '0;
            end else begin
                ch_cnt <= ch_cnt + CH_W'(1);
            end
        end
    end

    // Pipeline registers. Sideband (mode, channel, last) travels with the
    // beat so later mode changes never affect beats already in flight.
    always_ff @(posedge clk_en) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_prod   <= '0;
            s1_bias   <= '0;
            s1_mode   <= ACT_LINEAR;
            s1_ch     <= '0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            s2_v      <= '0;
            s2_mode   <= ACT_LINEAR;
            s2_ch     <= '0;
            s2_last   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_prod <= PROD_W'(in_data) * PROD_W'(scale_q[ch_cnt]);
                    s1_bias <= bias_q[ch_cnt];
                    s1_mode <= act_mode_t'(mode);
                    s1_ch   <= ch_cnt;
                    s1_last <= in_last;
                end
            end
            if (s2_en) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_v    <= s2_next;
                    s2_mode <= s1_mode;
                    s2_ch   <= s1_ch;
                    s2_last <= s1_last;
                end
            end
            if (s3_en) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_data <= act_out;
                    out_ch   <= s2_ch;
                    out_last <= s2_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_yolo_cbl_stream.sv
// ---------------------------------------------------------------------------
// tb_yolo_cbl_stream
// Scoreboard bench: each accepted beat pushes its expected result, computed
// from plain integer arithmetic, into a queue; a monitor on the falling edge
// compares whatever the DUT presents against the head of that queue.
// ---------------------------------------------------------------------------
module tb_yolo_cbl_stream;

    localparam int IN_WIDTH    = 16;
    localparam int OUT_WIDTH   = 8;
    localparam int COEF_WIDTH  = 8;
    localparam int FRAC_SHIFT  = 4;
    localparam int CHANNELS    = 4;
    localparam int LEAKY_SHIFT = 3;
    localparam int MAX_VAL     = 6;
    localparam int CH_W        = 2;
    localparam int BIAS_W      = OUT_WIDTH + 4;

    logic                         clk_en = 1'b0;
    logic                         rst;
    logic                         cfg_we;
    logic [CH_W-1:0]              cfg_ch;
    logic signed [COEF_WIDTH-1:0] cfg_scale;
    logic signed [BIAS_W-1:0]     cfg_bias;
    logic [1:0]                   mode;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [IN_WIDTH-1:0]   in_data;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_last;
    logic                         err_align;

    typedef struct {
        int data;
        int ch;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   model_scale [CHANNELS];
    int   model_bias  [CHANNELS];
    int   model_ch;
    bit   model_err;
    bit   rand_done;

    yolo_cbl_stream #(
        .IN_WIDTH    (IN_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .COEF_WIDTH  (COEF_WIDTH),
        .FRAC_SHIFT  (FRAC_SHIFT),
        .CHANNELS    (CHANNELS),
        .LEAKY_SHIFT (LEAKY_SHIFT),
        .MAX_VAL     (MAX_VAL)
    ) dut (
        .clk_en    (clk_en),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_scale (cfg_scale),
        .cfg_bias  (cfg_bias),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .err_align (err_align)
    );

    always #5 clk_en = ~clk_en;

    // Hard stop in case some handshake never completes.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint floor_div(input longint a, input longint b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    // Reference result straight from the arithmetic definition of the stage.
    function automatic int model_out(input int din, input int sc, input int bi, input int md);
        longint v;
        longint lo;
        longint hi;
        v  = floor_div(longint'(din) * sc + (1 << (FRAC_SHIFT - 1)), 1 << FRAC_SHIFT) + bi;
        lo = -(64'sd1 << (OUT_WIDTH - 1));
        hi = (64'sd1 << (OUT_WIDTH - 1)) - 1;
        case (md)
            1: if (v < 0) v = 0;
            2: begin
                if (v < 0) v = 0;
                if (v > MAX_VAL) v = MAX_VAL;
            end
            3: if (v < 0) v = floor_div(v, 1 << LEAKY_SHIFT);
            default: ;
        endcase
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return int'(v);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CHANNELS; i++) begin
            model_scale[i] = 1 << FRAC_SHIFT;
            model_bias[i]  = 0;
        end
        model_ch  = 0;
        model_err = 0;
    endtask

    // Record the expected response of a beat that the DUT is about to take,
    // then advance the channel model.
    task automatic model_accept(input int data, input bit last, input int md);
        exp_t e;
        e.data = model_out(data, model_scale[model_ch], model_bias[model_ch], md);
        e.ch   = model_ch;
        e.last = last;
        exp_q.push_back(e);
        if (last) begin
            if (model_ch != CHANNELS - 1) model_err = 1;
            model_ch = 0;
        end else begin
            model_ch = (model_ch + 1) % CHANNELS;
        end
    endtask

    // Present one beat; returns one edge after it was accepted (+#1).
    task automatic applyStimulus(input int data, input bit last, input int md);
        int waited;
        logic [31:0] raw;
        raw      = data;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = raw[IN_WIDTH-1:0];
        in_last  = last;
        mode     = 2'(md);
        @(negedge clk_en);
        while (!in_ready && waited < 100) begin
            @(negedge clk_en);
            waited++;
        end
        if (!in_ready) begin
            errors++;
            checks++;
            $display("[TB] FAIL accept_timeout: in_ready=%0d, expected 1", in_ready);
        end else begin
            model_accept(data, last, md);
        end
        @(posedge clk_en);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int sc, input int bi);
        logic [31:0] rs;
        logic [31:0] rb;
        rs        = sc;
        rb        = bi;
        cfg_we    = 1'b1;
        cfg_ch    = CH_W'(ch);
        cfg_scale = rs[COEF_WIDTH-1:0];
        cfg_bias  = rb[BIAS_W-1:0];
        @(posedge clk_en);
        #1;
        cfg_we = 1'b0;
        model_scale[ch] = sc;
        model_bias[ch]  = bi;
    endtask

    // One full frame: the value under test on channel 0, zero fillers after.
    task automatic send_frame(input int d0, input int md);
        applyStimulus(d0, 1'b0, md);
        for (int i = 1; i < CHANNELS; i++) applyStimulus(0, i == CHANNELS - 1, md);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk_en);
            #1;
            n++;
        end
        checkOutput("drain_queue_size", exp_q.size(), 0);
        @(posedge clk_en);
        #1;
    endtask

    // Scoreboard monitor: inputs only change just after rising edges, so
    // the falling edge sees exactly what the next rising edge will transfer.
    always @(negedge clk_en) begin
        if (!rst) begin
            checkOutput("in_ready_vs_stall", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got data %0d ch %0d, expected no beat",
                             $signed(out_data), out_ch);
                end else begin
                    mon_e = exp_q[0];
                    checkOutput("out_data", $signed(out_data), mon_e.data);
                    checkOutput("out_ch", out_ch, mon_e.ch);
                    checkOutput("out_last", out_last, mon_e.last);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_scale = '0;
        cfg_bias  = '0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rand_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_en);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_ch", out_ch, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_err_align", err_align, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        rst = 1'b0;

        // Latency: visible on the third edge counting the accepting edge.
        applyStimulus(100, 1'b0, 0);
        checkOutput("latency_edge1_valid", out_valid, 0);
        @(posedge clk_en);
        #1;
        checkOutput("latency_edge2_valid", out_valid, 0);
        @(posedge clk_en);
        #1;
        checkOutput("latency_edge3_valid", out_valid, 1);
        checkOutput("latency_data", $signed(out_data), 100);
        checkOutput("latency_ch", out_ch, 0);
        for (int i = 1; i < CHANNELS; i++) applyStimulus(0, i == CHANNELS - 1, 0);
        wait_drain();

        // Per-channel coefficients.
        write_cfg(1, 32, -5);
        applyStimulus(10, 1'b0, 0);
        applyStimulus(10, 1'b0, 0);
        applyStimulus(0, 1'b0, 0);
        applyStimulus(0, 1'b1, 0);
        wait_drain();

        // Rounding half up on both signs.
        write_cfg(0, 24, 0);
        send_frame(3, 0);
        send_frame(-3, 0);
        write_cfg(0, 16, 0);

        // Activation modes and saturation.
        send_frame(-40, 1);
        send_frame(-40, 3);
        send_frame(50, 2);
        send_frame(1000, 0);
        send_frame(-1000, 0);
        wait_drain();

        // A write on the accepting edge must not affect that beat.
        in_valid  = 1'b1;
        in_data   = 16'sd20;
        in_last   = 1'b0;
        mode      = 2'd0;
        cfg_we    = 1'b1;
        cfg_ch    = 2'd0;
        cfg_scale = 8'sd32;
        cfg_bias  = 12'sd0;
        @(negedge clk_en);
        checkOutput("same_cycle_in_ready", in_ready, 1);
        model_accept(20, 1'b0, 0);
        @(posedge clk_en);
        #1;
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        model_scale[0] = 32;
        model_bias[0]  = 0;
        for (int i = 1; i < CHANNELS; i++) applyStimulus(0, i == CHANNELS - 1, 0);
        send_frame(20, 0);
        wait_drain();
        write_cfg(0, 16, 0);

        // Backpressure: six back-to-back beats against a 5-cycle stall.
        fork
            begin
                for (int i = 0; i < 6; i++) applyStimulus(i * 7 - 9, i == 3, 0);
            end
            begin
                out_ready = 1'b0;
                repeat (4) @(posedge clk_en);
                #1;
                checkOutput("stall_in_ready", in_ready, 0);
                checkOutput("stall_out_valid", out_valid, 1);
                @(posedge clk_en);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Misaligned frame end: counter now at 2, realign then end early.
        applyStimulus(0, 1'b0, 0);
        applyStimulus(0, 1'b1, 0);
        checkOutput("aligned_err", err_align, 0);
        applyStimulus(5, 1'b0, 0);
        applyStimulus(6, 1'b1, 0);
        applyStimulus(7, 1'b0, 0);
        wait_drain();
        checkOutput("misaligned_err", err_align, 1);

        // Reset with beats in flight.
        applyStimulus(11, 1'b0, 0);
        applyStimulus(12, 1'b0, 0);
        applyStimulus(13, 1'b0, 0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk_en);
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_err_align", err_align, 0);
        checkOutput("midreset_out_ch", out_ch, 0);
        checkOutput("midreset_out_last", out_last, 0);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < CHANNELS; i++) applyStimulus(10, i == CHANNELS - 1, 0);
        wait_drain();

        // Randomised traffic, coefficients and backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    int d;
                    bit l;
                    if ($urandom_range(0, 9) == 0) begin
                        write_cfg(int'($urandom_range(0, CHANNELS - 1)),
                                  int'($urandom_range(0, 255)) - 128,
                                  int'($urandom_range(0, 4095)) - 2048);
                    end
                    if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 600)) - 300;
                    else d = int'($urandom_range(0, 65535)) - 32768;
                    if (model_ch == CHANNELS - 1) l = ($urandom_range(0, 7) != 0);
                    else l = ($urandom_range(0, 31) == 0);
                    applyStimulus(d, l, int'($urandom_range(0, 3)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk_en);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        checkOutput("random_err_align", err_align, model_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
